// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-control FSM driving program counter select/operand
// Optional interrupt entry enabled by macro PC_SEQ_IRQ_EN.
module pc_sequencer #(
`ifdef PC_SEQ_IRQ_EN
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0010,
`endif
  parameter logic [31:0] FAULT_VECTOR = 32'h0000_0004,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_rel,
  input  logic [31:0] br_target,
  input  logic        halt,
`ifdef PC_SEQ_IRQ_EN
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] epc,
`endif
  output logic [1:0]  ps,
  output logic [31:0] pc_in,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault
);

  localparam int CW = (IMEM_TIMEOUT > 2) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    FAULT,
    ISSUE,
    HALTED
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          irq_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      // Held at zero outside FETCH so every FETCH entry starts counting from 0.
      if (state != FETCH)
        wait_cnt <= '0;
      else if (!imem_ack)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef PC_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      epc <= '0;
    else if (irq_take)
      epc <= (state == HALTED) ? pc : pc + 32'd1;
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_comb begin
    next_state  = state;
    ps          = 2'b00;
    pc_in       = '0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    irq_take    = 1'b0;
    case (state)
      BOOT: next_state = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          next_state = ISSUE;
        else if (wait_cnt == CNT_LAST)
          next_state = FAULT;
      end
      FAULT: begin
        fault      = 1'b1;
        ps         = 2'b10;
        pc_in      = FAULT_VECTOR;
        next_state = FETCH;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (halt) begin
          next_state = HALTED;
        end else if (stall) begin
          next_state = ISSUE;
        end else if (br_valid) begin
          ps         = br_rel ? 2'b11 : 2'b10;
          pc_in      = br_target;
          next_state = FETCH;
`ifdef PC_SEQ_IRQ_EN
        end else if (irq) begin
          irq_take   = 1'b1;
          ps         = 2'b10;
          pc_in      = IRQ_VECTOR;
          next_state = FETCH;
`endif
        end else begin
          ps         = 2'b01;
          next_state = FETCH;
        end
      end
      HALTED: begin
        halted = 1'b1;
`ifdef PC_SEQ_IRQ_EN
        if (irq) begin
          halted     = 1'b0;
          irq_take   = 1'b1;
          ps         = 2'b10;
          pc_in      = IRQ_VECTOR;
          next_state = FETCH;
        end
`endif
      end
      default: next_state = BOOT;
    endcase
    // Outputs go quiet the moment rst rises, before the state register settles.
    if (rst) begin
      ps          = 2'b00;
      pc_in       = '0;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      fault       = 1'b0;
      irq_take    = 1'b0;
    end
  end

`ifdef PC_SEQ_IRQ_EN
  assign irq_ack = irq_take;
`endif

endmodule
